// File: rtl/bsg_credit_pool_arbiter_if.sv
// bsg_credit_pool_arbiter_if
//   Bundles the request/grant, credit-return, drain and status signals of
//   bsg_credit_pool_arbiter. The owner/requester side uses the master modport;
//   the arbiter uses the slave modport.
//   v_i             requester valids (one bit per requester)
//   yumi_o          one-hot grant, taken in the same cycle
//   grant_id_o      binary index of the granted requester (0 when idle)
//   credit_return_i one outstanding transaction completed
//   drain_i         level request to stop granting and quiesce
//   count_o         registered outstanding-credit count
//   full_o/empty_o  count at maximum / at zero
//   drained_o       pool is quiesced
//   underflow_o     sticky: a return arrived with nothing outstanding
interface bsg_credit_pool_arbiter_if #(
  parameter int num_req_p     = 4,
  parameter int max_credits_p = 8
);
  localparam int lg_credits_lp = $clog2(max_credits_p + 1);
  localparam int lg_req_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  logic [num_req_p-1:0]     v_i;
  logic [num_req_p-1:0]     yumi_o;
  logic [lg_req_lp-1:0]     grant_id_o;
  logic                     credit_return_i;
  logic                     drain_i;
  logic [lg_credits_lp-1:0] count_o;
  logic                     full_o;
  logic                     empty_o;
  logic                     drained_o;
  logic                     underflow_o;

  modport master (
    output v_i, credit_return_i, drain_i,
    input  yumi_o, grant_id_o, count_o, full_o, empty_o, drained_o, underflow_o
  );

  modport slave (
    input  v_i, credit_return_i, drain_i,
    output yumi_o, grant_id_o, count_o, full_o, empty_o, drained_o, underflow_o
  );
endinterface

// File: rtl/bsg_credit_pool_arbiter.sv
// bsg_credit_pool_arbiter
//   Shares a pool of max_credits_p outstanding-transaction credits among
//   num_req_p requesters with round-robin priority. An up/down counter tracks
//   outstanding grants; a RUN/DRAIN/DRAINED state machine lets the owner stop
//   new grants and wait for the pool to empty.
//   clk_i    clock, all state updates on the rising edge
//   reset_i  synchronous active-high reset
//   bus      slave side of bsg_credit_pool_arbiter_if (see that file)
module bsg_credit_pool_arbiter #(
  parameter int num_req_p     = 4,
  parameter int max_credits_p = 8
) (
  input logic                      clk_i,
  input logic                      reset_i,
  bsg_credit_pool_arbiter_if.slave bus
);
  localparam int lg_credits_lp = $clog2(max_credits_p + 1);
  localparam int lg_req_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [lg_credits_lp-1:0] max_cnt_lp  = lg_credits_lp'(max_credits_p);
  localparam logic [lg_req_lp-1:0]     last_rst_lp = lg_req_lp'(num_req_p - 1);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DRAINED = 2'd2} state_e;

  state_e                   state_q, state_d;
  logic [lg_credits_lp-1:0] count_q, count_d;
  logic [lg_req_lp-1:0]     last_q, last_d;
  logic                     underflow_q, underflow_d;

  logic                     grant_en;
  logic                     grant_v;
  logic                     ret_v;
  logic [num_req_p-1:0]     yumi;
  logic [lg_req_lp-1:0]     grant_id;

  // Grants depend only on registered count/state and drain_i, never on the
  // same-cycle credit return, so there is no return-to-grant path.
  assign grant_en = (state_q == RUN) & ~bus.drain_i & (count_q < max_cnt_lp);

  // Round-robin search starting one past the last winner, wrapping.
  always_comb begin
    logic [lg_req_lp-1:0] idx;
    yumi     = '0;
    grant_id = '0;
    grant_v  = 1'b0;
    idx      = '0;
    if (grant_en) begin
      for (int i = 1; i <= num_req_p; i++) begin
        idx = lg_req_lp'((int'(last_q) + i) % num_req_p);
        if (!grant_v && bus.v_i[idx]) begin
          grant_v   = 1'b1;
          yumi[idx] = 1'b1;
          grant_id  = idx;
        end
      end
    end
  end

  // A return with nothing outstanding is ignored by the counter and flagged.
  assign ret_v = bus.credit_return_i & (count_q != '0);

  always_comb begin
    count_d     = count_q;
    last_d      = grant_v ? grant_id : last_q;
    underflow_d = underflow_q | (bus.credit_return_i & (count_q == '0));
    case ({grant_v, ret_v})
      2'b10:   count_d = count_q + lg_credits_lp'(1);
      2'b01:   count_d = count_q - lg_credits_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain state machine; DRAIN exits to DRAINED on the cycle whose update
  // makes the count zero, so a final return is recognised immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.drain_i) state_d = (count_q == '0) ? DRAINED : DRAIN;
      end
      DRAIN: begin
        if (!bus.drain_i)        state_d = RUN;
        else if (count_d == '0)  state_d = DRAINED;
      end
      DRAINED: begin
        if (!bus.drain_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= RUN;
      count_q     <= '0;
      last_q      <= last_rst_lp;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_q      <= last_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.yumi_o      = yumi;
  assign bus.grant_id_o  = grant_id;
  assign bus.count_o     = count_q;
  assign bus.full_o      = (count_q == max_cnt_lp);
  assign bus.empty_o     = (count_q == '0);
  assign bus.drained_o   = (state_q == DRAINED);
  assign bus.underflow_o = underflow_q;
endmodule

// File: tb/tb_bsg_credit_pool_arbiter.sv
module tb_bsg_credit_pool_arbiter;
  localparam int NREQ = 4;
  localparam int MAXC = 3;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  bsg_credit_pool_arbiter_if #(.num_req_p(NREQ), .max_credits_p(MAXC)) bus ();

  bsg_credit_pool_arbiter #(.num_req_p(NREQ), .max_credits_p(MAXC)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       cr;
    logic       dr;
    logic [3:0] yumi;
    int         cnt;
    logic       drained;
    logic       under;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cnt, m_last, m_mode;
  bit m_und;

  task automatic add(input logic rst, input logic [3:0] v, input logic cr, input logic dr,
                     input logic [3:0] yumi, input int cnt, input logic drained, input logic under);
    vec_t r;
    r.rst = rst; r.v = v; r.cr = cr; r.dr = dr;
    r.yumi = yumi; r.cnt = cnt; r.drained = drained; r.under = under;
    vq.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] oh);
    int r = 0;
    for (int k = 0; k < NREQ; k++) if (oh[k]) r = k;
    return r;
  endfunction

  // Compare every observable output against expected values for one cycle.
  task automatic check_all(input string tag, input logic [3:0] yumi, input int cnt,
                           input logic drained, input logic under);
    check({tag, " yumi"},      32'(bus.yumi_o),      32'(yumi));
    check({tag, " grant_id"},  32'(bus.grant_id_o),  32'(onehot_idx(yumi)));
    check({tag, " count"},     32'(bus.count_o),     32'(cnt));
    check({tag, " full"},      32'(bus.full_o),      32'(cnt == MAXC));
    check({tag, " empty"},     32'(bus.empty_o),     32'(cnt == 0));
    check({tag, " drained"},   32'(bus.drained_o),   32'(drained));
    check({tag, " underflow"}, 32'(bus.underflow_o), 32'(under));
  endtask

  // Round-robin winner from the requirements: first set valid after last.
  function automatic int model_winner(input logic [3:0] v, input logic dr);
    if (m_mode != M_RUN || dr || m_cnt >= MAXC) return -1;
    for (int k = 1; k <= NREQ; k++)
      if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_last = NREQ - 1; m_mode = M_RUN; m_und = 0;
  endtask

  task automatic model_step(input logic rst, input logic [3:0] v, input logic cr, input logic dr);
    int w, old_cnt;
    if (rst) begin
      model_reset();
      return;
    end
    w = model_winner(v, dr);
    old_cnt = m_cnt;
    if (cr && m_cnt == 0) m_und = 1;
    if (w >= 0) m_cnt++;
    if (cr && old_cnt > 0) m_cnt--;
    if (w >= 0) m_last = w;
    case (m_mode)
      M_RUN:     if (dr) m_mode = (old_cnt == 0) ? M_DRAINED : M_DRAIN;
      M_DRAIN:   if (!dr) m_mode = M_RUN; else if (m_cnt == 0) m_mode = M_DRAINED;
      default:   if (!dr) m_mode = M_RUN;
    endcase
  endtask

  initial begin
    logic [3:0] rv, ey;
    logic rr, rc, rd;
    int w;

    reset_i = 1'b1;
    bus.v_i = '0;
    bus.credit_return_i = 1'b0;
    bus.drain_i = 1'b0;

    //   rst  v      cr dr  yumi   cnt drained under
    // fill from reset: three grants then full
    add(0, 4'hF, 0, 0, 4'b0001, 0, 0, 0);
    add(0, 4'hF, 0, 0, 4'b0010, 1, 0, 0);
    add(0, 4'hF, 0, 0, 4'b0100, 2, 0, 0);
    add(0, 4'hF, 0, 0, 4'b0000, 3, 0, 0);
    // return at full does not enable a same-cycle grant
    add(0, 4'hF, 1, 0, 4'b0000, 3, 0, 0);
    add(0, 4'hF, 0, 0, 4'b1000, 2, 0, 0);
    add(0, 4'h0, 0, 0, 4'b0000, 3, 0, 0);
    add(0, 4'h0, 1, 0, 4'b0000, 3, 0, 0);
    add(0, 4'h0, 1, 0, 4'b0000, 2, 0, 0);
    // grant and return together: count holds, pointer moves to 0
    add(0, 4'b0001, 1, 0, 4'b0001, 1, 0, 0);
    add(0, 4'hF, 0, 0, 4'b0010, 1, 0, 0);
    // drain with two outstanding
    add(0, 4'hF, 0, 1, 4'b0000, 2, 0, 0);
    add(0, 4'hF, 1, 1, 4'b0000, 2, 0, 0);
    add(0, 4'hF, 1, 1, 4'b0000, 1, 0, 0);
    add(0, 4'hF, 0, 1, 4'b0000, 0, 1, 0);
    add(0, 4'hF, 0, 0, 4'b0000, 0, 1, 0);
    add(0, 4'hF, 0, 0, 4'b0100, 0, 0, 0);
    // underflow is sticky until reset
    add(1, 4'h0, 0, 0, 4'b0000, 1, 0, 0);
    add(0, 4'h0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'h0, 0, 0, 4'b0000, 0, 0, 1);
    add(0, 4'h0, 0, 0, 4'b0000, 0, 0, 1);
    add(1, 4'h0, 0, 0, 4'b0000, 0, 0, 1);
    // reset while draining with count 2, pointer 2
    add(0, 4'b0010, 0, 0, 4'b0010, 0, 0, 0);
    add(0, 4'b0100, 0, 0, 4'b0100, 1, 0, 0);
    add(0, 4'h0, 0, 1, 4'b0000, 2, 0, 0);
    add(1, 4'h0, 0, 1, 4'b0000, 2, 0, 0);
    add(0, 4'b1010, 0, 0, 4'b0010, 0, 0, 0);
    add(0, 4'h0, 0, 0, 4'b0000, 1, 0, 0);
    // drain at zero goes straight to DRAINED
    add(0, 4'h0, 1, 0, 4'b0000, 1, 0, 0);
    add(0, 4'hF, 0, 1, 4'b0000, 0, 0, 0);
    add(0, 4'h0, 0, 1, 4'b0000, 0, 1, 0);
    add(0, 4'h0, 0, 0, 4'b0000, 0, 1, 0);
    add(0, 4'hF, 0, 0, 4'b0100, 0, 0, 0);
    // drain withdrawn before emptying
    add(0, 4'h0, 0, 1, 4'b0000, 1, 0, 0);
    add(0, 4'hF, 0, 0, 4'b0000, 1, 0, 0);
    add(0, 4'hF, 0, 0, 4'b1000, 1, 0, 0);

    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      reset_i = vq[i].rst;
      bus.v_i = vq[i].v;
      bus.credit_return_i = vq[i].cr;
      bus.drain_i = vq[i].dr;
      #1;
      check_all($sformatf("vec%0d", i), vq[i].yumi, vq[i].cnt, vq[i].drained, vq[i].under);
    end

    // hand-written sequence: reset asserted mid-flight with inputs active
    @(negedge clk);
    reset_i = 1'b1; bus.v_i = 4'hF; bus.credit_return_i = 1'b1; bus.drain_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0; bus.v_i = 4'b1100; bus.credit_return_i = 1'b0;
    #1;
    check_all("post_reset", 4'b0100, 0, 0, 0);

    // randomized phase against the reference model
    @(negedge clk);
    reset_i = 1'b1; bus.v_i = '0; bus.credit_return_i = 1'b0; bus.drain_i = 1'b0;
    model_reset();
    rd = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rr = ($urandom_range(299) == 0);
      rv = 4'($urandom_range(15));
      rc = ($urandom_range(2) == 0);
      if ($urandom_range(19) == 0) rd = ~rd;
      reset_i = rr; bus.v_i = rv; bus.credit_return_i = rc; bus.drain_i = rd;
      #1;
      w = model_winner(rv, rd);
      ey = (w >= 0) ? 4'(1 << w) : 4'b0000;
      check_all($sformatf("rand%0d", n), ey, m_cnt, (m_mode == M_DRAINED), m_und);
      model_step(rr, rv, rc, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
